// File: rtl/seg7_digit_monitor_pkg.sv
// seg7_digit_monitor_pkg: segment code table and monitor FSM state shared by the seg7 display path.
package seg7_digit_monitor_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7C;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;
  localparam logic [6:0] SEG_TABLE [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;
endpackage

// File: rtl/seg7_digit_monitor_if.sv
// seg7_digit_monitor_if: segment input and decoded digit/checker outputs of the monitor.
interface seg7_digit_monitor_if #(parameter int CNT_WIDTH = 24);
  logic [6:0] seg_in;
  logic clear_errors;
  logic [3:0] digit;
  logic digit_valid;
  logic digit_strobe;
  logic pattern_error;
  logic seq_error;
  logic rate_error;
  logic [CNT_WIDTH-1:0] interval;
  logic interval_valid;
  modport master (
    output seg_in, clear_errors,
    input digit, digit_valid, digit_strobe, pattern_error, seq_error, rate_error, interval, interval_valid
  );
  modport slave (
    input seg_in, clear_errors,
    output digit, digit_valid, digit_strobe, pattern_error, seq_error, rate_error, interval, interval_valid
  );
endinterface

// File: rtl/seg7_digit_monitor_decode.sv
// seg7_decode: combinational inverse of the seg7 encoder; anything outside the table is invalid.
module seg7_decode
  import seg7_digit_monitor_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);
  always_comb begin
    digit = '0;
    valid = 1'b0;
    for (int i = 0; i < 10; i++)
      if (pattern == SEG_TABLE[i]) begin
        digit = 4'(i);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/seg7_digit_monitor.sv
// seg7_digit_monitor: syncs, debounces and decodes a 7-seg pattern, checking digit order and tick period.
module seg7_digit_monitor
  import seg7_digit_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH = 24,
  parameter logic [CNT_WIDTH-1:0] EXPECTED_TICK = CNT_WIDTH'(10_000_001),
  parameter logic [CNT_WIDTH-1:0] TOLERANCE = CNT_WIDTH'(16)
) (
  input logic clk,
  input logic reset,
  seg7_digit_monitor_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  logic [6:0] s1, s2, cand, last;
  logic [SW-1:0] stab, stab_nxt;
  logic [CNT_WIDTH-1:0] cnt, meas;
  logic [3:0] dec_digit;
  logic dec_valid, accept, seq_bad, rate_bad;
  state_t state;
  seg7_decode u_dec (.pattern(s2), .digit(dec_digit), .valid(dec_valid));
  // Accept is judged on the filter's next state so the strobe lands STABLE_CYCLES+2 clocks after the edge.
  always_comb begin
    stab_nxt = (s2 != cand) ? '0 : (stab == STAB_MAX) ? stab : stab + 1'b1;
    accept = (stab_nxt == STAB_MAX) && (s2 != last);
    meas = &cnt ? cnt : cnt + 1'b1;
    seq_bad = dec_digit != ((bus.digit == 4'd9) ? 4'd0 : bus.digit + 4'd1);
    rate_bad = &meas || ({1'b0, meas} + {1'b0, TOLERANCE} < {1'b0, EXPECTED_TICK})
            || ({1'b0, meas} > {1'b0, EXPECTED_TICK} + {1'b0, TOLERANCE});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, cand, last} <= '0;
      stab <= '0;
      cnt <= '0;
      state <= IDLE;
      bus.digit <= '0;
      bus.digit_valid <= 1'b0;
      bus.digit_strobe <= 1'b0;
      bus.pattern_error <= 1'b0;
      bus.seq_error <= 1'b0;
      bus.rate_error <= 1'b0;
      bus.interval <= '0;
      bus.interval_valid <= 1'b0;
    end else begin
      s1 <= bus.seg_in;
      s2 <= s1;
      cand <= s2;
      stab <= stab_nxt;
      cnt <= accept ? '0 : meas;
      bus.digit_strobe <= accept && dec_valid;
      bus.pattern_error <= accept && !dec_valid;
      bus.seq_error <= bus.seq_error && !bus.clear_errors;
      bus.rate_error <= bus.rate_error && !bus.clear_errors;
      if (accept) begin
        last <= s2;
        if (dec_valid) begin
          bus.digit <= dec_digit;
          bus.digit_valid <= 1'b1;
          state <= (state == IDLE) ? FIRST : TRACK;
          if (state != IDLE) begin
            bus.interval <= meas;
            bus.interval_valid <= 1'b1;
            if (seq_bad) bus.seq_error <= 1'b1;
          end
          if (state == TRACK && rate_bad) bus.rate_error <= 1'b1;
        end else begin
          bus.digit_valid <= 1'b0;
          bus.interval_valid <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_digit_monitor.sv
// tb_seg7_digit_monitor: directed table plus random stimulus checked cycle by cycle against a history-based model.
module tb_seg7_digit_monitor;
  localparam int S = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  seg7_digit_monitor_if #(.CNT_WIDTH(24)) bus ();
  seg7_digit_monitor #(
    .STABLE_CYCLES(S), .CNT_WIDTH(24), .EXPECTED_TICK(24'd100), .TOLERANCE(24'd2)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0] seg;
    int hold;
    bit clr;
    int ns;
    int np;
    int dig;
    bit dv;
    bit ivv;
    int ival;
    bit seq;
    bit rate;
  } vec_t;
  vec_t rows [21];
  int codes [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7C, 'h07, 'h7F, 'h67};
  int total = 0;
  int bad = 0;
  int strobes = 0;
  int perrs = 0;
  int hist [$] = '{0, 0, 0};
  int t = 0;
  int t_last = 0;
  int last_acc = 0;
  int m_digit = 0;
  int m_n = 0;
  int m_ival = 0;
  bit m_dv = 0, m_strobe = 0, m_perr = 0, m_seq = 0, m_rate = 0, m_ivv = 0;
  function automatic logic [33:0] dut_out();
    return {bus.digit, bus.digit_valid, bus.digit_strobe, bus.pattern_error, bus.seq_error,
            bus.rate_error, bus.interval, bus.interval_valid};
  endfunction
  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0d)", name, act, exp, t);
    end
  endtask
  // Model: accept when the last S synchronised samples agree and differ from the last accepted pattern.
  task automatic model_step();
    int n, p, d, meas;
    bit run_ok, seq_set, rate_set;
    t++;
    m_strobe = 0;
    m_perr = 0;
    if (reset) begin
      hist = '{0, 0, 0};
      last_acc = 0;
      t_last = t;
      m_digit = 0; m_n = 0; m_ival = 0;
      m_dv = 0; m_seq = 0; m_rate = 0; m_ivv = 0;
    end else begin
      hist.push_back(int'(bus.seg_in));
      if (hist.size() > 16) void'(hist.pop_front());
      n = hist.size();
      p = hist[n-3];
      run_ok = 1;
      seq_set = 0;
      rate_set = 0;
      for (int k = 0; k < S; k++) if (n - 3 - k < 0 || hist[n-3-k] != p) run_ok = 0;
      if (run_ok && p != last_acc) begin
        last_acc = p;
        d = -1;
        for (int i = 0; i < 10; i++) if (codes[i] == p) d = i;
        if (d >= 0) begin
          m_strobe = 1;
          if (m_n > 0) begin
            seq_set = d != (m_digit + 1) % 10;
            meas = (t - t_last > 24'hFFFFFF) ? 24'hFFFFFF : t - t_last;
            m_ival = meas;
            m_ivv = 1;
            if (m_n > 1) rate_set = meas < 98 || meas > 102;
          end
          m_digit = d;
          m_dv = 1;
          m_n = (m_n < 2) ? m_n + 1 : 2;
        end else begin
          m_perr = 1;
          m_dv = 0;
          m_ivv = 0;
          m_n = 0;
        end
        t_last = t;
      end
      m_seq = seq_set ? 1'b1 : bus.clear_errors ? 1'b0 : m_seq;
      m_rate = rate_set ? 1'b1 : bus.clear_errors ? 1'b0 : m_rate;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", dut_out(), {4'(m_digit), m_dv, m_strobe, m_perr, m_seq, m_rate, 24'(m_ival), m_ivv});
    strobes += int'(bus.digit_strobe);
    perrs += int'(bus.pattern_error);
  endtask
  task automatic run_rows(input int lo, input int hi);
    int s0, p0;
    for (int i = lo; i <= hi; i++) begin
      s0 = strobes;
      p0 = perrs;
      bus.seg_in = rows[i].seg;
      bus.clear_errors = rows[i].clr;
      tick();
      bus.clear_errors = 1'b0;
      repeat (rows[i].hold - 1) tick();
      check($sformatf("row%0d", i),
            {2'b0, 8'(strobes - s0), 8'(perrs - p0), 4'(bus.digit), bus.digit_valid, bus.interval_valid,
             bus.interval, bus.seq_error, bus.rate_error},
            {2'b0, 8'(rows[i].ns), 8'(rows[i].np), 4'(rows[i].dig), rows[i].dv, rows[i].ivv,
             24'(rows[i].ival), rows[i].seq, rows[i].rate});
    end
  endtask
  initial begin
    int s0, p0, wait_n, nd, r, hold;
    rows[0] = '{7'h3F, 100, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 1; i <= 10; i++) rows[i] = '{7'(codes[i%10]), 100, 0, 1, 0, i % 10, 1, 1, 100, 0, 0};
    rows[11] = '{7'h06, 60, 0, 1, 0, 1, 1, 1, 100, 0, 0};
    rows[12] = '{7'h5B, 100, 0, 1, 0, 2, 1, 1, 100, 0, 0};
    rows[13] = '{7'h4F, 110, 0, 1, 0, 3, 1, 1, 100, 0, 0};
    rows[14] = '{7'h66, 101, 0, 1, 0, 4, 1, 1, 110, 0, 1};
    rows[15] = '{7'h6D, 100, 1, 1, 0, 5, 1, 1, 101, 0, 0};
    rows[16] = '{7'h3F, 100, 0, 1, 0, 0, 1, 1, 100, 1, 0};
    rows[17] = '{7'h4F, 100, 0, 1, 0, 3, 1, 1, 100, 1, 0};
    rows[18] = '{7'h66, 100, 1, 1, 0, 4, 1, 1, 100, 0, 0};
    rows[19] = '{7'h00, 50, 0, 0, 1, 4, 0, 0, 100, 0, 0};
    rows[20] = '{7'h06, 100, 0, 1, 0, 1, 1, 0, 100, 0, 0};
    bus.seg_in = 7'h00;
    bus.clear_errors = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", dut_out(), 34'd0);
    run_rows(0, 11);
    s0 = strobes;
    p0 = perrs;
    bus.seg_in = 7'h7F;
    repeat (3) tick();
    bus.seg_in = 7'h06;
    repeat (37) tick();
    check("glitch", {8'(strobes - s0), 8'(perrs - p0), 4'(bus.digit)}, {8'd0, 8'd0, 4'd1});
    run_rows(12, 20);
    s0 = strobes;
    bus.seg_in = 7'h5B;
    repeat (4) tick();
    check("pre_reset_no_strobe", 34'(strobes - s0), 34'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset", dut_out(), 34'd0);
    wait_n = 0;
    while (!bus.digit_strobe && wait_n < 20) begin
      tick();
      wait_n++;
    end
    check("reset_latency", {30'(wait_n), bus.digit}, {30'd6, 4'd2});
    nd = 3;
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 99));
      hold = int'($urandom_range(95, 106));
      if (r < 70) begin
        bus.seg_in = 7'(codes[nd]);
        nd = (nd + 1) % 10;
      end else if (r < 80) bus.seg_in = 7'(codes[$urandom_range(0, 9)]);
      else if (r < 88) bus.seg_in = 7'($urandom);
      else if (r < 96) begin
        bus.seg_in = 7'($urandom);
        hold = int'($urandom_range(1, 3));
      end else begin
        reset = 1'b1;
        hold = 1;
      end
      for (int c = 0; c < hold; c++) begin
        bus.clear_errors = ($urandom_range(0, 7) == 0);
        tick();
      end
      reset = 1'b0;
      bus.clear_errors = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
